// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480 @ 60 Hz VGA timing from the 100 MHz system clock.
// A free-running divider produces one pixel period every CLK_DIV clocks. The
// x/y raster counters advance once per pixel period. The syncs and the
// active-video flag are registered from the next-state counter values, so
// every output changes on the same clk edge and stays aligned with x/y.
module vga_sync_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       frame_tick
);

    localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACTIVE = 10'(H_DISPLAY);
    localparam logic [9:0] V_ACTIVE = 10'(V_DISPLAY);
    localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] div;
    logic             pix_end;
    logic             h_wrap;
    logic             v_wrap;
    logic [9:0]       x_next;
    logic [9:0]       y_next;

    // Next raster position; the counters only move in the last clock of a pixel.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        x_next  = x;
        y_next  = y;
        pix_end = (div == DIV_LAST);
        h_wrap  = pix_end && (x == H_LAST);
        v_wrap  = h_wrap && (y == V_LAST);
        if (pix_end) begin
            x_next = h_wrap ? 10'd0 : x + 10'd1;
        end
        if (h_wrap) begin
            y_next = v_wrap ? 10'd0 : y + 10'd1;
        end
    end

    // Divider, counters and all flags share one register stage so they stay aligned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div        <= '0;
            x          <= 10'd0;
            y          <= 10'd0;
            p_tick     <= 1'b0;
            frame_tick <= 1'b0;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            video_on   <= 1'b1;  // (0,0) is an active pixel
        end else begin
            // NOTE: non-blocking assignments, so every register samples the
            // pre-edge values and the flags see x_next/y_next, not each other.
            div        <= div + DIV_W'(1);
            p_tick     <= pix_end;
            frame_tick <= v_wrap;
            x          <= x_next;
            y          <= y_next;
            hsync      <= !((x_next >= HS_FIRST) && (x_next <= HS_LAST));
            vsync      <= !((y_next >= VS_FIRST) && (y_next <= VS_LAST));
            video_on   <= (x_next < H_ACTIVE) && (y_next < V_ACTIVE);
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed bench for vga_sync_gen.
// Instance u_a uses the default 640x480 timing and covers reset, pixel rate,
// the hsync window and a line wrap. Instance u_b uses a shrunken raster
// (25x15 pixels, CLK_DIV=2) so that frame wraps, the vsync window, frame_tick
// spacing and a mid-frame reset glitch fit in a short run.
// The expected outputs come from the number of clock edges since reset release.
module tb_vga_sync_gen;

    // Timing of u_b (shrunken raster)
    localparam int B_DIV = 2;
    localparam int B_HD  = 16;
    localparam int B_HFP = 2;
    localparam int B_HS  = 4;
    localparam int B_HBP = 3;
    localparam int B_VD  = 8;
    localparam int B_VFP = 2;
    localparam int B_VS  = 2;
    localparam int B_VBP = 3;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    logic       a_p_tick, a_hsync, a_vsync, a_video_on, a_frame_tick;
    logic [9:0] a_x, a_y;
    logic       b_p_tick, b_hsync, b_vsync, b_video_on, b_frame_tick;
    logic [9:0] b_x, b_y;

    int checks = 0;
    int errors = 0;
    int tick_seen = 0;
    int ft_q[$];

    always #5 clk = ~clk;

    vga_sync_gen u_a (
        .clk       (clk),
        .reset     (rst_a),
        .p_tick    (a_p_tick),
        .x         (a_x),
        .y         (a_y),
        .hsync     (a_hsync),
        .vsync     (a_vsync),
        .video_on  (a_video_on),
        .frame_tick(a_frame_tick)
    );

    vga_sync_gen #(
        .CLK_DIV  (B_DIV),
        .H_DISPLAY(B_HD),
        .H_FP     (B_HFP),
        .H_SYNC   (B_HS),
        .H_BP     (B_HBP),
        .V_DISPLAY(B_VD),
        .V_FP     (B_VFP),
        .V_SYNC   (B_VS),
        .V_BP     (B_VBP)
    ) u_b (
        .clk       (clk),
        .reset     (rst_b),
        .p_tick    (b_p_tick),
        .x         (b_x),
        .y         (b_y),
        .hsync     (b_hsync),
        .vsync     (b_vsync),
        .video_on  (b_video_on),
        .frame_tick(b_frame_tick)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Check every output of one instance right after reset is applied.
    task automatic check_reset(input bit use_b, input string pfx);
        if (use_b) begin
            check({pfx, ".x"}, 32'(b_x), 0);
            check({pfx, ".y"}, 32'(b_y), 0);
            check({pfx, ".hsync"}, 32'(b_hsync), 1);
            check({pfx, ".vsync"}, 32'(b_vsync), 1);
            check({pfx, ".video_on"}, 32'(b_video_on), 1);
            check({pfx, ".p_tick"}, 32'(b_p_tick), 0);
            check({pfx, ".frame_tick"}, 32'(b_frame_tick), 0);
        end else begin
            check({pfx, ".x"}, 32'(a_x), 0);
            check({pfx, ".y"}, 32'(a_y), 0);
            check({pfx, ".hsync"}, 32'(a_hsync), 1);
            check({pfx, ".vsync"}, 32'(a_vsync), 1);
            check({pfx, ".video_on"}, 32'(a_video_on), 1);
            check({pfx, ".p_tick"}, 32'(a_p_tick), 0);
            check({pfx, ".frame_tick"}, 32'(a_frame_tick), 0);
        end
    endtask

    // Sample one instance at each falling edge; n is the count of rising edges
    // since reset was released, from which every expected output follows.
    task automatic run_check(input bit use_b, input int cycles, input int start_n);
        int dv, htot, vtot, hs0, hs1, vs0, vs1, hd, vd;
        int pix, ex, ey, etick, eft, ehs, evs, evid;
        logic       ot, ohs, ovs, ovid, oft;
        logic [9:0] ox, oy;
        string      pfx;
        if (use_b) begin
            dv = B_DIV; hd = B_HD; vd = B_VD;
            htot = B_HD + B_HFP + B_HS + B_HBP;
            vtot = B_VD + B_VFP + B_VS + B_VBP;
            hs0 = B_HD + B_HFP; hs1 = hs0 + B_HS - 1;
            vs0 = B_VD + B_VFP; vs1 = vs0 + B_VS - 1;
            pfx = "b";
        end else begin
            dv = 4; hd = 640; vd = 480; htot = 800; vtot = 525;
            hs0 = 656; hs1 = 751; vs0 = 490; vs1 = 491;
            pfx = "a";
        end
        for (int n = start_n; n < start_n + cycles; n++) begin
            @(negedge clk);
            pix   = n / dv;
            ex    = pix % htot;
            ey    = (pix / htot) % vtot;
            etick = (n % dv == 0) ? 1 : 0;
            eft   = (etick == 1 && pix % (htot * vtot) == 0) ? 1 : 0;
            ehs   = (ex >= hs0 && ex <= hs1) ? 0 : 1;
            evs   = (ey >= vs0 && ey <= vs1) ? 0 : 1;
            evid  = (ex < hd && ey < vd) ? 1 : 0;
            if (use_b) begin
                ot = b_p_tick; ox = b_x; oy = b_y; ohs = b_hsync;
                ovs = b_vsync; ovid = b_video_on; oft = b_frame_tick;
            end else begin
                ot = a_p_tick; ox = a_x; oy = a_y; ohs = a_hsync;
                ovs = a_vsync; ovid = a_video_on; oft = a_frame_tick;
            end
            if (ot) tick_seen++;
            if (use_b && oft) ft_q.push_back(n);
            check($sformatf("%s.p_tick@%0d", pfx, n), 32'(ot), etick);
            check($sformatf("%s.x@%0d", pfx, n), 32'(ox), ex);
            check($sformatf("%s.y@%0d", pfx, n), 32'(oy), ey);
            check($sformatf("%s.hsync@%0d", pfx, n), 32'(ohs), ehs);
            check($sformatf("%s.vsync@%0d", pfx, n), 32'(ovs), evs);
            check($sformatf("%s.video_on@%0d", pfx, n), 32'(ovid), evid);
            check($sformatf("%s.frame_tick@%0d", pfx, n), 32'(oft), eft);
        end
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_reset(1'b0, "a.rst0");
        check_reset(1'b1, "b.rst0");

        // ---- u_a: first pixel on edge 4, then ten ticks in 40 clocks
        rst_a = 1'b0;
        tick_seen = 0;
        run_check(1'b0, 40, 1);
        check("a.ticks_in_40", 32'(tick_seen), 10);

        // ---- u_a: rest of line 0 (hsync window, video_on drop) and the wrap to line 1
        run_check(1'b0, 3260, 41);

        // ---- u_a: run to x=300 on line 1 (tick edge), then reset asynchronously
        run_check(1'b0, 1100, 3301);
        check("a.pre_rst.x", 32'(a_x), 300);
        check("a.pre_rst.y", 32'(a_y), 1);
        check("a.pre_rst.p_tick", 32'(a_p_tick), 1);
        #2 rst_a = 1'b1;
        #1 check_reset(1'b0, "a.rst_mid");
        @(negedge clk);
        @(negedge clk);
        check_reset(1'b0, "a.rst_hold");
        rst_a = 1'b0;
        run_check(1'b0, 12, 1);

        // ---- u_b: two full frames; frame_tick spacing equals the frame length
        ft_q.delete();
        rst_b = 1'b0;
        run_check(1'b1, 1600, 1);
        check("b.frame_ticks", 32'(ft_q.size()), 2);
        if (ft_q.size() == 2) begin
            check("b.frame_period", 32'(ft_q[1] - ft_q[0]), 750);
            check("b.first_frame_tick", 32'(ft_q[0]), 750);
        end

        // ---- u_b: one-cycle reset pulse while vsync is low
        run_check(1'b1, 420, 1601);
        check("b.pre_glitch.vsync", 32'(b_vsync), 0);
        check("b.pre_glitch.y", 32'(b_y), 10);
        #2 rst_b = 1'b1;
        #1 check_reset(1'b1, "b.glitch");
        @(negedge clk);
        rst_b = 1'b0;
        ft_q.delete();
        run_check(1'b1, 760, 1);
        check("b.post_glitch.frame_ticks", 32'(ft_q.size()), 1);
        if (ft_q.size() == 1) begin
            check("b.post_glitch.frame_at", 32'(ft_q[0]), 750);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Generates 640x480 @ 60 Hz VGA timing from the 100 MHz system clock. Produces the pixel-enable tick, horizontal/vertical sync, the active-video flag, and the current pixel coordinates `x`/`y`. Every display block (background, sprite and title ROM readers) consumes these coordinates and decides whether its pixel is on. All outputs are registered and change on the same `clk` edge, so the coordinates and syncs stay mutually aligned.

## Interface

- `CLK_DIV`, 4: `clk` cycles per pixel; a power of two no smaller than 2.
- `H_DISPLAY`, 640: active pixels per line.
- `H_FP`, 16: horizontal front porch.
- `H_SYNC`, 96: hsync pulse width.
- `H_BP`, 48: horizontal back porch. `H_TOTAL` is the sum of the four, 800.
- `V_DISPLAY`, 480: active lines.
- `V_FP`, 10: vertical front porch.
- `V_SYNC`, 2: vsync pulse width.
- `V_BP`, 33: vertical back porch. `V_TOTAL` is the sum of the four, 525.
- `clk` in 1: system clock, 100 MHz.
- `reset` in 1: asynchronous, active-high reset.
- `p_tick` out 1: one-`clk` pulse per pixel period.
- `x` out 10: current pixel column, 0..H_TOTAL-1.
- `y` out 10: current line, 0..V_TOTAL-1.
- `hsync` out 1: horizontal sync, active-low.
- `vsync` out 1: vertical sync, active-low.
- `video_on` out 1: high while `x < H_DISPLAY` and `y < V_DISPLAY`.
- `frame_tick` out 1: one-`clk` pulse when the coordinates wrap to (0,0).

## Operation

- **Divider.** `div` is a log2(CLK_DIV)-bit counter, free-running, incrementing every `clk` and wrapping naturally.
- **Pixel tick.** `p_tick` is registered. It is high for exactly one cycle when `div` transitions from CLK_DIV-1 to 0, giving a period of exactly CLK_DIV cycles.
- **Horizontal counter.** On each cycle where `div == CLK_DIV-1`:
  - if `x == H_TOTAL-1`, `x` becomes 0; otherwise `x` increments.
- **Vertical counter.** `y` updates only on a horizontal wrap:
  - if `y == V_TOTAL-1`, `y` becomes 0; otherwise `y` increments.
- **Sync and video flags.** `hsync`, `vsync` and `video_on` are registered from the next-state counter values, so they always match the `x`/`y` presented in the same cycle.
  - `hsync` = 0 iff `x` is in [H_DISPLAY+H_FP, H_DISPLAY+H_FP+H_SYNC-1], i.e. [656, 751].
  - `vsync` = 0 iff `y` is in [V_DISPLAY+V_FP, V_DISPLAY+V_FP+V_SYNC-1], i.e. [490, 491].
  - `video_on` = (next `x` < 640) && (next `y` < 480).
- **Frame tick.** `frame_tick` is high for one cycle, on the same edge where (799,524) becomes (0,0). It coincides with that cycle's `p_tick`.
- **Coordinate hold.** `x`/`y` hold their value for CLK_DIV cycles. Downstream synchronous ROMs add one cycle of latency, which fits inside the pixel period.
- **Range.** All arithmetic is 10-bit unsigned. Values above H_TOTAL-1 or V_TOTAL-1 are unreachable.

## Timing

- **Reset values** (asynchronous, immediate on `reset` high):
  - `div` = 0, `x` = 0, `y` = 0
  - `p_tick` = 0, `frame_tick` = 0
  - `hsync` = 1, `vsync` = 1
  - `video_on` = 1, consistent with (0,0) being active.
- **First pixel after reset.** The first `p_tick` occurs on the CLK_DIV-th rising edge after `reset` deasserts, i.e. edge 4. On that same edge `x` becomes 1.
- **Rates.** Line = 800×4 = 3200 `clk`; frame = 525 lines = 1,680,000 `clk`.
- **Output alignment.** Every output changes only on a `p_tick` edge; `p_tick` itself changes on the cycle before and the cycle of the tick. No output is combinational.
- **Simultaneous wrap.** Horizontal and vertical wraps on the same edge produce `x`=0, `y`=0, `frame_tick`=1, `vsync`=1 and `video_on`=1 together.
- **Reset mid-frame.** Counters return to (0,0) immediately. There is no partial-frame `frame_tick`. Counting restarts exactly as after power-up.

## Test plan

- **Reset values.** Assert `reset` mid-line at `x`=300, `y`=200 → same cycle: `x`=0, `y`=0, `hsync`=1, `vsync`=1, `video_on`=1, `p_tick`=0. After release, first `p_tick` and `x`=1 appear on edge 4.
- **Tick period.** Run 40 cycles → `p_tick` is high exactly 10 times, spaced 4 cycles apart. `x` steps 0..10 with no skips.
- **Line wrap.** Advance to `x`=799, `y`=5 → next tick gives `x`=0, `y`=6. `video_on` goes 0 at `x`=640 and returns to 1 at `x`=0.
- **Hsync window.** Across one line, `hsync`=0 for `x`=656..751 (96 ticks = 384 `clk`) and 1 elsewhere.
- **Frame wrap.** At `x`=799, `y`=524 → next tick gives (0,0) with a single-cycle `frame_tick`. `vsync`=0 only for `y`=490..491. `video_on`=0 for all `y` ≥ 480. Consecutive `frame_tick` pulses are 1,680,000 cycles apart.
- **Reset glitch.** Pulse `reset` for 1 cycle during `vsync`=0 → `vsync` goes to 1 immediately, `y`=0, and no `frame_tick` is issued.
